// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto a level-handshake SDRAM port,
// with read-modify-write for sub-word stores. Define ARB_ROUND_ROBIN_EN for alternating priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_wr_req,
    input  logic              mem_wr_fin,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              mem_rd_req,
    input  logic              mem_rd_fin,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_WAIT  = 3'd1;
    localparam logic [2:0] S_RD_REL   = 3'd2;
    localparam logic [2:0] S_WR_WAIT  = 3'd3;
    localparam logic [2:0] S_WR_REL   = 3'd4;
    localparam logic [2:0] S_RMW_RD   = 3'd5;
    localparam logic [2:0] S_RMW_RREL = 3'd6;

    // Handshake: each client holds req until a one-cycle ack; memory req/fin are
    // four-phase levels (req up, fin up, req down, fin down) and only one memory req is ever high.
    logic [2:0]        state;
    logic              grant_d;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic [31:0]       lat_wdata;
    logic              pick_d;
    logic              mem_idle;
    logic [31:0]       merged;
    logic [31:0]       load_word;

    assign dbg_state = state;
    assign mem_idle  = !mem_rd_fin && !mem_wr_fin;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_d;
    logic grant_done;

    assign grant_done = (state == S_RD_WAIT && mem_rd_fin) || (state == S_WR_WAIT && mem_wr_fin);
    assign pick_d     = d_req && (!i_req || prio_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_d <= 1'b1;
        end else if (grant_done) begin
            prio_d <= !grant_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    // Memory words are big-endian, so the addressed byte/half lives in the top bits.
    always_comb begin
        merged = mem_rd_data;
        if (lat_size == 2'd0) begin
            merged = {lat_wdata[7:0], mem_rd_data[23:0]};
        end else if (lat_size == 2'd1) begin
            merged = {lat_wdata[15:0], mem_rd_data[15:0]};
        end
    end

    always_comb begin
        case (lat_size)
            2'd0:    load_word = {24'b0, mem_rd_data[31:24]};
            2'd1:    load_word = {16'b0, mem_rd_data[31:16]};
            default: load_word = mem_rd_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            grant_d     <= 1'b0;
            lat_addr    <= '0;
            lat_size    <= 2'd0;
            lat_wdata   <= '0;
            i_ack       <= 1'b0;
            i_data      <= '0;
            d_ack       <= 1'b0;
            d_rdata     <= '0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_idle && (i_req || d_req)) begin
                        grant_d <= pick_d;
                        if (pick_d) begin
                            lat_addr  <= d_addr;
                            lat_size  <= d_size;
                            lat_wdata <= d_wdata;
                            if (d_we && d_size[1]) begin
                                mem_wr_req  <= 1'b1;
                                mem_wr_addr <= d_addr;
                                mem_wr_data <= d_wdata;
                                state       <= S_WR_WAIT;
                            end else begin
                                mem_rd_req  <= 1'b1;
                                mem_rd_addr <= d_addr;
                                state       <= d_we ? S_RMW_RD : S_RD_WAIT;
                            end
                        end else begin
                            lat_addr    <= i_addr;
                            lat_size    <= 2'd2;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= i_addr;
                            state       <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rd_fin) begin
                        mem_rd_req <= 1'b0;
                        if (grant_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= load_word;
                        end else begin
                            i_ack  <= 1'b1;
                            i_data <= mem_rd_data;
                        end
                        state <= S_RD_REL;
                    end
                end
                S_RD_REL: begin
                    if (!mem_rd_fin) begin
                        state <= S_IDLE;
                    end
                end
                S_RMW_RD: begin
                    if (mem_rd_fin) begin
                        mem_rd_req  <= 1'b0;
                        mem_wr_data <= merged;
                        state       <= S_RMW_RREL;
                    end
                end
                S_RMW_RREL: begin
                    if (!mem_rd_fin) begin
                        mem_wr_req  <= 1'b1;
                        mem_wr_addr <= lat_addr;
                        state       <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (mem_wr_fin) begin
                        mem_wr_req <= 1'b0;
                        d_ack      <= 1'b1;
                        state      <= S_WR_REL;
                    end
                end
                S_WR_REL: begin
                    if (!mem_wr_fin) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: word-keyed memory responder, vector table, arbitration,
// reset-abort sequence and randomized traffic against a reference model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_data;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_wr_req;
    logic        mem_wr_fin;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd_req;
    logic        mem_rd_fin;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [2:0]  dbg_state;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_wr_req(mem_wr_req), .mem_wr_fin(mem_wr_fin), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_req(mem_rd_req), .mem_rd_fin(mem_rd_fin),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory responder: full words keyed by byte address
    logic [31:0] mem_arr [logic [31:0]];
    bit          rd_hold = 1'b0;
    int          rd_wait = 0;
    int          wr_wait = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_word(a);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd_fin  <= 1'b0;
            mem_wr_fin  <= 1'b0;
            mem_rd_data <= '0;
            rd_wait     <= 0;
            wr_wait     <= 0;
        end else begin
            if (mem_rd_req && !mem_rd_fin && !rd_hold) begin
                if (rd_wait == 0) begin
                    mem_rd_fin   <= 1'b1;
                    mem_rd_data  <= mem_word(mem_rd_addr);
                    rd_cnt       <= rd_cnt + 1;
                    last_rd_addr <= mem_rd_addr;
                    rd_wait      <= int'($urandom_range(0, 3));
                end else begin
                    rd_wait <= rd_wait - 1;
                end
            end else if (!mem_rd_req && mem_rd_fin) begin
                mem_rd_fin <= 1'b0;
            end
            if (mem_wr_req && !mem_wr_fin) begin
                if (wr_wait == 0) begin
                    mem_wr_fin   <= 1'b1;
                    mem_arr[mem_wr_addr] = mem_wr_data;
                    wr_cnt       <= wr_cnt + 1;
                    last_wr_addr <= mem_wr_addr;
                    last_wr_data <= mem_wr_data;
                    wr_wait      <= int'($urandom_range(0, 3));
                end else begin
                    wr_wait <= wr_wait - 1;
                end
            end else if (!mem_wr_req && mem_wr_fin) begin
                mem_wr_fin <= 1'b0;
            end
        end
    end

    // ack / exclusivity monitor
    int i_ack_cnt = 0;
    int d_ack_cnt = 0;
    int overlap_cnt = 0;
    bit ack_order[$];

    always @(negedge clk) begin
        if (i_ack) begin
            i_ack_cnt++;
            ack_order.push_back(1'b0);
        end
        if (d_ack) begin
            d_ack_cnt++;
            ack_order.push_back(1'b1);
        end
        if (mem_rd_req && mem_wr_req) overlap_cnt++;
    end

    // driver tasks
    task automatic run_i(input logic [31:0] a, output logic [31:0] data, output logic ok);
        i_addr = a;
        i_req  = 1'b1;
        ok     = 1'b0;
        data   = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (i_ack) begin
                data = i_data;
                ok   = 1'b1;
                break;
            end
        end
        i_req = 1'b0;
    endtask

    task automatic run_d(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] data, output logic ok);
        d_we    = we;
        d_size  = sz;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        ok      = 1'b0;
        data    = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (d_ack) begin
                data = d_rdata;
                ok   = 1'b1;
                break;
            end
        end
        d_req = 1'b0;
    endtask

    // reference model: memory contents and sub-word rules by plain arithmetic
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return w / 32'h0100_0000;
        if (sz == 2'd1) return w / 32'h0001_0000;
        return w;
    endfunction

    function automatic logic [31:0] ref_store(input logic [1:0] sz, input logic [31:0] old,
                                              input logic [31:0] wd);
        if (sz == 2'd0) return (old % 32'h0100_0000) + (wd % 32'h100) * 32'h0100_0000;
        if (sz == 2'd1) return (old % 32'h0001_0000) + (wd % 32'h1_0000) * 32'h0001_0000;
        return wd;
    endfunction

    typedef struct {
        bit          is_d;
        bit          we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        int          n_rd;
        int          n_wr;
    } vec_t;

    localparam int NV = 9;
    vec_t        vecs [NV];
    logic [31:0] res;
    logic        ok;
    int          rc0, wc0, ia0, da0;
    logic [31:0] exp_idata;
    logic [31:0] exp_drdata;
    logic [31:0] exp_q[$];
    logic [3:0]  order_val;
    logic [3:0]  exp_order;

    initial begin
        reset   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 2'd0;
        d_addr  = '0;
        d_wdata = '0;

        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h100, 32'h0,         32'hDEADBEEF, 1, 0};
        vecs[1] = '{1'b1, 1'b1, 2'd2, 32'h20,  32'h12345678,  32'h12345678, 0, 1};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h20,  32'h0,         32'h12345678, 1, 0};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h20,  32'h555555AB,  32'hAB345678, 1, 1};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 32'h20,  32'h0,         32'h0000AB34, 1, 0};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 32'h20,  32'h0,         32'h000000AB, 1, 0};
        vecs[6] = '{1'b1, 1'b1, 2'd1, 32'h20,  32'h1234CAFE,  32'hCAFE5678, 1, 1};
        vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h20,  32'h0,         32'hCAFE5678, 1, 0};
        vecs[8] = '{1'b0, 1'b0, 2'd2, 32'h20,  32'h0,         32'hCAFE5678, 1, 0};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctrl", {28'b0, i_ack, d_ack, mem_wr_req, mem_rd_req}, 32'h0);
        check("rst_i_data", i_data, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_rd_addr", mem_rd_addr, 32'h0);
        check("rst_wr_addr", mem_wr_addr, 32'h0);
        check("rst_wr_data", mem_wr_data, 32'h0);
        check("rst_state", {29'b0, dbg_state}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // vector table
        exp_idata  = 32'h0;
        exp_drdata = 32'h0;
        for (int k = 0; k < NV; k++) begin
            rc0 = rd_cnt;
            wc0 = wr_cnt;
            ia0 = i_ack_cnt;
            da0 = d_ack_cnt;
            if (vecs[k].is_d) run_d(vecs[k].we, vecs[k].sz, vecs[k].addr, vecs[k].wd, res, ok);
            else              run_i(vecs[k].addr, res, ok);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_done", k), {31'b0, ok}, 32'h1);
            if (vecs[k].we) begin
                check($sformatf("v%0d_wr_data", k), last_wr_data, vecs[k].exp);
                check($sformatf("v%0d_wr_addr", k), last_wr_addr, vecs[k].addr);
            end else begin
                check($sformatf("v%0d_rd_data", k), res, vecs[k].exp);
                check($sformatf("v%0d_rd_addr", k), last_rd_addr, vecs[k].addr);
                if (vecs[k].is_d) exp_drdata = vecs[k].exp;
                else              exp_idata  = vecs[k].exp;
            end
            check($sformatf("v%0d_n_rd", k), rd_cnt - rc0, vecs[k].n_rd);
            check($sformatf("v%0d_n_wr", k), wr_cnt - wc0, vecs[k].n_wr);
            check($sformatf("v%0d_i_acks", k), i_ack_cnt - ia0, vecs[k].is_d ? 0 : 1);
            check($sformatf("v%0d_d_acks", k), d_ack_cnt - da0, vecs[k].is_d ? 1 : 0);
            check($sformatf("v%0d_i_hold", k), i_data, exp_idata);
            check($sformatf("v%0d_d_hold", k), d_rdata, exp_drdata);
        end

        // both ports pending together; data keeps re-requesting
        ack_order.delete();
        fork
            begin
                logic [31:0] r0;
                logic        k0;
                for (int n = 0; n < 3; n++) begin
                    run_d(1'b0, 2'd2, 32'h20, 32'h0, r0, k0);
                    @(negedge clk);
                end
            end
            begin
                logic [31:0] r1;
                logic        k1;
                run_i(32'h100, r1, k1);
            end
        join
        repeat (4) @(negedge clk);
        check("arb_count", ack_order.size(), 4);
        order_val = '0;
        for (int n = 0; n < 4 && n < ack_order.size(); n++) order_val[3-n] = ack_order[n];
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b1011;
`else
        exp_order = 4'b1110;
`endif
        check("arb_order", {28'b0, order_val}, {28'b0, exp_order});

        // reset while waiting on a read
        rd_hold = 1'b1;
        ia0     = i_ack_cnt;
        i_addr  = 32'h300;
        i_req   = 1'b1;
        ok      = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (mem_rd_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_mid_started", {31'b0, ok}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_rd_req", {31'b0, mem_rd_req}, 32'h0);
        check("rst_mid_i_ack", {31'b0, i_ack}, 32'h0);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        rd_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_no_ack", i_ack_cnt - ia0, 0);
        run_i(32'h100, res, ok);
        repeat (3) @(negedge clk);
        check("rst_after_done", {31'b0, ok}, 32'h1);
        check("rst_after_data", res, 32'hDEADBEEF);

        // randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [1:0]  sz;
            logic [31:0] nw;
            a  = 32'h200 + $urandom_range(0, 5);
            wd = $urandom;
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin
                    exp_q.push_back(ref_word(a));
                    run_i(a, res, ok);
                end
                1: begin
                    exp_q.push_back(ref_load(sz, ref_word(a)));
                    run_d(1'b0, sz, a, wd, res, ok);
                end
                default: begin
                    nw = ref_store(sz, ref_word(a), wd);
                    ref_mem[a] = nw;
                    exp_q.push_back(nw);
                    run_d(1'b1, sz, a, wd, res, ok);
                    res = last_wr_data;
                end
            endcase
            repeat (2 + $urandom_range(0, 2)) @(negedge clk);
            check($sformatf("rnd%0d_done", n), {31'b0, ok}, 32'h1);
            check($sformatf("rnd%0d_data", n), res, exp_q.pop_front());
        end

        check("req_exclusive", overlap_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
